usb_tx_pkt_ctrl: RTL and testbench
==================================

# usb_tx_pkt_ctrl

Packet sequencer for the USB low-speed transmit path. It accepts a packet request (PID, optional payload of up to 8 bytes held in an external byte buffer), frames it as PID byte, payload and CRC16, and streams the bytes into the serial sender's data/valid/ready handshake. It then waits for the EOP to finish and enforces an inter-packet gap before reporting completion. It sits between the SIE transaction logic and the low-speed serial sender.

## Interface
- IDLE_GAP, 32: clk cycles held in GAP after the sender releases the bus, before `done`.
- MAX_LEN, 8: maximum payload bytes; `len` above this is clamped to MAX_LEN.
- clk  in  1  system clock (24 MHz)
- reset  in  1  synchronous, active-high
- start  in  1  packet request; sampled only in IDLE
- pid  in  4  packet ID nibble
- has_data  in  1  1: send payload plus CRC16; 0: send the PID byte only (token/handshake)
- len  in  4  payload byte count 0..8; ignored when has_data=0
- buf_addr  out  3  payload buffer read address; read data returns one cycle later
- buf_rdata  in  8  payload buffer read data
- tx_data  out  8  byte presented to the sender
- tx_valid  out  1  to sender: rise starts SYNC, high while bytes remain, fall requests EOP
- tx_ready  in  1  one-cycle pulse from sender; the byte on tx_data in that cycle is captured
- tx_d_en  in  1  sender line-drive enable; falls when EOP completes
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at end of gap

## Operation
- Byte sequence, index k:
  - k=0: PID byte = {~pid, pid}.
  - k=1..L: buffer bytes at addresses 0..L-1, where L = min(len, MAX_LEN).
  - k=L+1: CRC low byte; k=L+2: CRC high byte.
  - Total N = 1 if has_data=0, else L+3.
- CRC16 covers payload bytes only.
  - Reflected polynomial 0xA001, LSB-first, initialised to 0xFFFF on start.
  - The transmitted value is ~crc, low byte first.
  - Zero-length payload transmits 0x00, 0x00.
- States:
  - IDLE: on start, capture pid/len/has_data, clear the byte index and CRC, issue buf_addr=0 → LOAD.
  - LOAD: drive tx_data = PID byte and tx_valid=1 → SEND.
  - SEND: prefetch byte k+1 into a holding register (buffer read and CRC update complete within 2 cycles). On each tx_ready, tx_data ← byte k+1 the next cycle and k increments. When the ready that captures byte N-1 occurs → DRAIN.
  - DRAIN: on the next tx_ready (end of the final byte), clear tx_valid the following cycle → EOPW.
  - EOPW: wait for tx_d_en 1→0 → GAP.
  - GAP: count IDLE_GAP cycles → IDLE, with done=1 for that one cycle.
- tx_ready outside SEND/DRAIN is ignored.
- A start while busy is ignored and does not queue.
- Reset in any state: the next edge returns to IDLE with tx_valid=0, busy=0, done=0, tx_data=0x00, buf_addr=0, CRC=0xFFFF. No EOP is generated by this block.

## Timing
- Reset values: tx_valid=0, tx_data=0x00, buf_addr=0, busy=0, done=0.
- tx_valid rises exactly 2 cycles after the start cycle. busy rises 1 cycle after start.
- tx_data update latency after tx_ready: 1 cycle. The sender spaces readies ≥16 clk apart, so the prefetch always completes.
- tx_valid falls exactly 1 cycle after the (N+1)th tx_ready.
- done is asserted IDLE_GAP+1 cycles after tx_d_en is seen low in EOPW. busy falls in the same cycle as done.
- tx_data holds steady between tx_ready pulses.

## Test plan
- Handshake: has_data=0, pid=0x2 (ACK), bench sender model pulses tx_ready every 16 clk → tx_data 0xD2 captured once; tx_valid falls 1 cycle after the 2nd ready; done after EOP + 33 cycles.
- Zero-length DATA: pid=0x3, has_data=1, len=0 → captured bytes 0xC3, 0x00, 0x00; tx_valid falls after the 4th ready.
- One-byte DATA: pid=0xB, buffer[0]=0x00, len=1 → captured bytes 0x4B, 0x00, 0x40, 0xBF.
- Eight-byte DATA and clamp: len=15, buffer 0x01..0x08 → exactly 11 bytes captured, addresses 0..7 read in order; CRC matches the bench model.
- start pulsed during SEND and during GAP → ignored, no second packet; busy stays high until the single done.
- Reset asserted mid-SEND (after 2 readies) → next cycle tx_valid=0, busy=0; a fresh start produces the full correct sequence.

Source files
------------

// File: rtl/usb_tx_pkt_ctrl.sv
// usb_tx_pkt_ctrl
// Packet sequencer for the USB low-speed transmit path. It frames one packet
// and streams it to the serial sender. A packet is the PID byte, then an
// optional payload read from an external byte buffer, then the CRC16 of that
// payload. After the last byte it waits for the sender to finish EOP, and it
// holds an inter-packet gap before it pulses done.
//
// Parameters
//   IDLE_GAP   clk cycles spent in the gap after the sender releases the bus
//   MAX_LEN    maximum payload bytes; larger len requests are clamped
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   start      in   packet request, accepted only while idle
//   pid        in   [3:0] packet ID nibble
//   has_data   in   1: payload + CRC16 follow the PID, 0: PID byte only
//   len        in   [3:0] payload byte count (ignored when has_data=0)
//   buf_addr   out  [2:0] payload buffer read address
//   buf_rdata  in   [7:0] payload buffer data, valid one cycle after address
//   tx_data    out  [7:0] byte presented to the sender
//   tx_valid   out  high while bytes remain; its fall requests EOP
//   tx_ready   in   one-cycle capture pulse from the sender
//   tx_d_en    in   sender line-drive enable; falls when EOP completes
//   busy       out  high from start acceptance until done
//   done       out  one-cycle pulse at the end of the gap

module usb_tx_pkt_ctrl #(
    parameter int IDLE_GAP = 32,
    parameter int MAX_LEN  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] pid,
    input  logic       has_data,
    input  logic [3:0] len,
    output logic [2:0] buf_addr,
    input  logic [7:0] buf_rdata,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       tx_d_en,
    output logic       busy,
    output logic       done
);

    localparam int              GW        = $clog2(IDLE_GAP + 1);
    localparam logic [GW-1:0]   GAP_LAST  = GW'(IDLE_GAP - 1);
    localparam logic [3:0]      MAX_LEN4  = 4'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        DRAIN,
        EOPW,
        GAP
    } state_t;

    state_t        state, state_next;

    logic [3:0]    pid_q, pid_next;
    logic          has_data_q, has_data_next;
    logic [3:0]    len_q, len_next;
    logic [3:0]    idx, idx_next;
    logic [15:0]   crc, crc_next;
    logic [7:0]    hold_byte, hold_byte_next;
    logic          hold_full, hold_full_next;
    logic          rd_ok, rd_ok_next;
    logic [2:0]    buf_addr_next;
    logic [7:0]    tx_data_next;
    logic          tx_valid_next;
    logic          busy_next;
    logic          done_next;
    logic [GW-1:0] gap_cnt, gap_cnt_next;
    logic          d_en_q;

    logic [3:0]    last_idx;
    logic [3:0]    fetch_idx;

    // Reflected CRC16 (poly 0xA001), one byte folded in LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in,
                                               input logic [7:0]  d);
        logic [15:0] c;
        c = c_in ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Index of the final byte: 0 for PID-only packets, else PID + L + 2 CRC bytes.
    assign last_idx  = has_data_q ? (len_q + 4'd2) : 4'd0;
    assign fetch_idx = idx + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        pid_next       = pid_q;
        has_data_next  = has_data_q;
        len_next       = len_q;
        idx_next       = idx;
        crc_next       = crc;
        hold_byte_next = hold_byte;
        hold_full_next = hold_full;
        // buf_rdata matches buf_addr once the address has been stable a cycle.
        rd_ok_next     = 1'b1;
        buf_addr_next  = buf_addr;
        tx_data_next   = tx_data;
        tx_valid_next  = tx_valid;
        busy_next      = busy;
        done_next      = 1'b0;
        gap_cnt_next   = gap_cnt;

        unique case (state)
            IDLE: begin
                if (start) begin
                    pid_next       = pid;
                    has_data_next  = has_data;
                    len_next       = (len > MAX_LEN4) ? MAX_LEN4 : len;
                    idx_next       = 4'd0;
                    crc_next       = 16'hFFFF;
                    hold_full_next = 1'b0;
                    buf_addr_next  = 3'd0;
                    rd_ok_next     = 1'b0;
                    busy_next      = 1'b1;
                    state_next     = LOAD;
                end
            end

            LOAD: begin
                tx_data_next  = {~pid_q, pid_q};
                tx_valid_next = 1'b1;
                state_next    = SEND;
            end

            SEND: begin
                if (tx_ready) begin
                    if (idx == last_idx) begin
                        state_next = DRAIN;
                    end else begin
                        tx_data_next   = hold_byte;
                        idx_next       = fetch_idx;
                        hold_full_next = 1'b0;
                    end
                end else if (!hold_full && (fetch_idx <= last_idx)) begin
                    // Prefetch the byte after the one the sender is shifting.
                    // CRC bytes are only fetched after the last payload byte
                    // has been folded into crc, so crc is final by then.
                    if (fetch_idx <= len_q) begin
                        if (rd_ok) begin
                            hold_byte_next = buf_rdata;
                            crc_next       = crc16_byte(crc, buf_rdata);
                            hold_full_next = 1'b1;
                            if (fetch_idx < len_q) begin
                                buf_addr_next = buf_addr + 3'd1;
                                rd_ok_next    = 1'b0;
                            end
                        end
                    end else if (fetch_idx == (len_q + 4'd1)) begin
                        hold_byte_next = ~crc[7:0];
                        hold_full_next = 1'b1;
                    end else begin
                        hold_byte_next = ~crc[15:8];
                        hold_full_next = 1'b1;
                    end
                end
            end

            DRAIN: begin
                // The ready here marks the end of the final byte on the wire.
                if (tx_ready) begin
                    tx_valid_next = 1'b0;
                    state_next    = EOPW;
                end
            end

            EOPW: begin
                if (d_en_q && !tx_d_en) begin
                    gap_cnt_next = '0;
                    state_next   = GAP;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pid_q      <= 4'd0;
            has_data_q <= 1'b0;
            len_q      <= 4'd0;
            idx        <= 4'd0;
            crc        <= 16'hFFFF;
            hold_byte  <= 8'h00;
            hold_full  <= 1'b0;
            rd_ok      <= 1'b0;
            buf_addr   <= 3'd0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            gap_cnt    <= '0;
            d_en_q     <= 1'b0;
        end else begin
            pid_q      <= pid_next;
            has_data_q <= has_data_next;
            len_q      <= len_next;
            idx        <= idx_next;
            crc        <= crc_next;
            hold_byte  <= hold_byte_next;
            hold_full  <= hold_full_next;
            rd_ok      <= rd_ok_next;
            buf_addr   <= buf_addr_next;
            tx_data    <= tx_data_next;
            tx_valid   <= tx_valid_next;
            busy       <= busy_next;
            done       <= done_next;
            gap_cnt    <= gap_cnt_next;
            d_en_q     <= tx_d_en;
        end
    end

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// tb_usb_tx_pkt_ctrl
// Directed testbench for usb_tx_pkt_ctrl. A behavioural sender pulses
// tx_ready every 17 clk while tx_valid is high and drops tx_d_en a few
// cycles after tx_valid falls. A registered byte buffer model answers
// buf_addr one cycle later.

module tb_usb_tx_pkt_ctrl;

    localparam int IDLE_GAP = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] pid;
    logic       has_data;
    logic [3:0] len;
    logic [2:0] buf_addr;
    logic [7:0] buf_rdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_d_en;
    logic       busy;
    logic       done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] mem [8];
    logic [7:0] exp_bytes [$];
    logic [7:0] captured [$];
    logic [2:0] addr_log [$];

    always #5 clk = ~clk;

    usb_tx_pkt_ctrl #(
        .IDLE_GAP (IDLE_GAP),
        .MAX_LEN  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pid       (pid),
        .has_data  (has_data),
        .len       (len),
        .buf_addr  (buf_addr),
        .buf_rdata (buf_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_d_en   (tx_d_en),
        .busy      (busy),
        .done      (done)
    );

    always @(posedge clk) begin
        buf_rdata <= mem[buf_addr];
    end

    // Record each new buffer address seen while a packet is in flight.
    always @(negedge clk) begin
        if (busy && (addr_log.size() == 0 || addr_log[addr_log.size()-1] != buf_addr)) begin
            addr_log.push_back(buf_addr);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] p, input logic hd, input logic [3:0] l);
        addr_log.delete();
        pid      = p;
        has_data = hd;
        len      = l;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Independent bit-serial CRC16 model (reflected 0xA001, init 0xFFFF).
    task automatic buildExpected(input logic [3:0] p, input logic [3:0] l);
        logic [15:0] c;
        int          n;
        logic        fb;
        n = (l > 4'd8) ? 8 : int'(l);
        c = 16'hFFFF;
        exp_bytes.delete();
        exp_bytes.push_back({~p, p});
        for (int i = 0; i < n; i++) begin
            exp_bytes.push_back(mem[i]);
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ mem[i][b];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        end
        c = ~c;
        exp_bytes.push_back(c[7:0]);
        exp_bytes.push_back(c[15:8]);
    endtask

    task automatic runPacket(input string tag, input logic [3:0] p, input logic hd,
                             input logic [3:0] l, input bit poke);
        logic [7:0] sample;
        logic [7:0] ref_byte;
        int         readies;
        int         changes;
        int         done_at;
        int         early_low;
        int         stray;
        logic       busy_at_done;
        bit         finished;

        applyStimulus(p, hd, l);
        checkOutput({tag, " busy+1"}, busy, 1);
        checkOutput({tag, " valid+1"}, tx_valid, 0);
        tick();
        checkOutput({tag, " valid+2"}, tx_valid, 1);
        tx_d_en = 1'b1;

        captured.delete();
        readies  = 0;
        changes  = 0;
        finished = 1'b0;
        for (int r = 0; r < 20 && !finished; r++) begin
            ref_byte = tx_data;
            for (int w = 0; w < 15; w++) begin
                tick();
                start = (poke && r == 1 && w == 5);
                if (tx_data !== ref_byte) changes++;
            end
            tick();
            tx_ready = 1'b1;
            sample   = tx_data;
            readies++;
            tick();
            tx_ready = 1'b0;
            if (tx_valid) captured.push_back(sample);
            else          finished = 1'b1;
        end

        checkOutput({tag, " readies"}, readies, exp_bytes.size() + 1);
        checkOutput({tag, " nbytes"}, captured.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++) begin
            if (i < captured.size()) begin
                checkOutput($sformatf("%s byte%0d", tag, i), captured[i], exp_bytes[i]);
            end
        end
        checkOutput({tag, " steady"}, changes, 0);

        repeat (4) tick();
        tx_d_en   = 1'b0;
        done_at   = -1;
        early_low = 0;
        busy_at_done = 1'b1;
        for (int c = 1; c <= 80 && done_at < 0; c++) begin
            tick();
            start = (poke && c == 10);
            if (done) begin
                done_at      = c;
                busy_at_done = busy;
            end else if (!busy) begin
                early_low++;
            end
        end
        start = 1'b0;
        checkOutput({tag, " done_lat"}, done_at, IDLE_GAP + 1);
        checkOutput({tag, " busy@done"}, busy_at_done, 0);
        checkOutput({tag, " busy_early"}, early_low, 0);
        tick();
        checkOutput({tag, " done_pulse"}, done, 0);

        if (poke) begin
            stray = 0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (busy || tx_valid) stray++;
            end
            checkOutput({tag, " no_requeue"}, stray, 0);
        end
        repeat (3) tick();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        pid      = 4'h0;
        has_data = 1'b0;
        len      = 4'd0;
        tx_ready = 1'b0;
        tx_d_en  = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;

        repeat (3) tick();
        checkOutput("rst tx_valid", tx_valid, 0);
        checkOutput("rst tx_data", tx_data, 8'h00);
        checkOutput("rst buf_addr", buf_addr, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        reset = 1'b0;
        repeat (2) tick();

        // ACK handshake, PID only.
        exp_bytes = '{8'hD2};
        runPacket("ack", 4'h2, 1'b0, 4'd0, 1'b0);

        // Zero-length DATA; starts poked during SEND and GAP must be ignored.
        exp_bytes = '{8'hC3, 8'h00, 8'h00};
        runPacket("zlp", 4'h3, 1'b1, 4'd0, 1'b1);

        // One payload byte 0x00.
        mem[0]    = 8'h00;
        exp_bytes = '{8'h4B, 8'h00, 8'h40, 8'hBF};
        runPacket("one", 4'hB, 1'b1, 4'd1, 1'b0);

        // Eight payload bytes, len clamped from 15.
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
        buildExpected(4'h3, 4'd15);
        runPacket("clamp", 4'h3, 1'b1, 4'd15, 1'b0);
        checkOutput("clamp nbytes11", captured.size(), 11);
        checkOutput("clamp naddr", addr_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < addr_log.size()) begin
                checkOutput($sformatf("clamp addr%0d", i), addr_log[i], i);
            end
        end

        // Reset in the middle of SEND, after two readies.
        applyStimulus(4'hB, 1'b1, 4'd8);
        tick();
        tx_d_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            repeat (16) tick();
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checkOutput("mid_rst tx_valid", tx_valid, 0);
        checkOutput("mid_rst busy", busy, 0);
        checkOutput("mid_rst tx_data", tx_data, 8'h00);
        checkOutput("mid_rst buf_addr", buf_addr, 0);
        checkOutput("mid_rst done", done, 0);
        reset   = 1'b0;
        tx_d_en = 1'b0;
        repeat (3) tick();

        buildExpected(4'hB, 4'd8);
        runPacket("after_rst", 4'hB, 1'b1, 4'd8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
